// File: rtl/ws2812_pixel_encoder.sv
// WS2812 single-wire pixel encoder: shifts pixel words out MSB-first as RZ pulses
// and inserts latch (reset) low periods on request.
module ws2812_pixel_encoder #(
   parameter int unsigned BITS    = 24,
   parameter int unsigned T_BIT   = 125,
   parameter int unsigned T0H     = 35,
   parameter int unsigned T1H     = 70,
   parameter int unsigned T_LATCH = 5000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            latch_req,
   output logic            data_out,
   output logic            busy,
   output logic            latch_done
);

   localparam int unsigned CNT_W = $clog2(T_BIT);
   localparam int unsigned LAT_W = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
   localparam int unsigned IDX_W = (BITS > 1) ? $clog2(BITS) : 1;

   if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT && BITS >= 1 && T_LATCH >= 1)) begin : g_param_check
      $error("ws2812_pixel_encoder: illegal BITS/timing parameters");
   end

   typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

   state_t            state;
   logic [BITS-1:0]   sr;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [LAT_W-1:0]  lat_cnt;
   logic              pending;

   logic              bit_end;
   logic              word_end;
   logic              accept;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  high_len;
   logic [LAT_W-1:0]  lat_nxt;

   assign bit_end  = (state == BIT) && (cnt == CNT_W'(T_BIT - 1));
   assign word_end = bit_end && (idx == IDX_W'(BITS - 1));
   assign cnt_nxt  = cnt + CNT_W'(1);
   assign lat_nxt  = lat_cnt + LAT_W'(1);
   assign high_len = sr[BITS-1] ? CNT_W'(T1H) : CNT_W'(T0H);

   // Ready in IDLE or in the last cycle of a word, so words chain without a gap.
   assign in_ready = !rst && !pending && !latch_req && ((state == IDLE) || word_end);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         cnt        <= '0;
         idx        <= '0;
         lat_cnt    <= '0;
         pending    <= 1'b0;
         data_out   <= 1'b0;
         busy       <= 1'b0;
         latch_done <= 1'b0;
      end else begin
         latch_done <= 1'b0;
         case (state)
            IDLE: begin
               if (latch_req) begin
                  state      <= LATCH;
                  lat_cnt    <= '0;
                  busy       <= 1'b1;
                  latch_done <= (T_LATCH == 1);
               end else if (accept) begin
                  state    <= BIT;
                  sr       <= in_data;
                  cnt      <= '0;
                  idx      <= '0;
                  data_out <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            BIT: begin
               if (!bit_end) begin
                  cnt      <= cnt_nxt;
                  data_out <= (cnt_nxt < high_len);
                  pending  <= pending | latch_req;
               end else if (!word_end) begin
                  sr       <= sr << 1;
                  idx      <= idx + IDX_W'(1);
                  cnt      <= '0;
                  data_out <= 1'b1;
                  pending  <= pending | latch_req;
               end else if (pending || latch_req) begin
                  state      <= LATCH;
                  pending    <= 1'b0;
                  lat_cnt    <= '0;
                  data_out   <= 1'b0;
                  latch_done <= (T_LATCH == 1);
               end else if (accept) begin
                  sr       <= in_data;
                  idx      <= '0;
                  cnt      <= '0;
                  data_out <= 1'b1;
               end else begin
                  state    <= IDLE;
                  data_out <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            LATCH: begin
               // latch_req is deliberately ignored here.
               if (lat_cnt == LAT_W'(T_LATCH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  lat_cnt    <= lat_nxt;
                  latch_done <= (lat_nxt == LAT_W'(T_LATCH - 1));
               end
            end
            default: begin
               state    <= IDLE;
               data_out <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ws2812_pixel_encoder.md
WS2812_PIXEL_ENCODER -- requirements
Module: ws2812_pixel_encoder

Interface
REQ-001 Parameter BITS, default 24, SHALL set the pixel word width (24 for RGB, 32 for RGBW), transmitted MSB-first.
REQ-002 Parameter T_BIT, default 125, SHALL set the bit period in clk cycles.
REQ-003 Parameter T0H, default 35, SHALL set the high time of a 0 bit in clk cycles.
REQ-004 Parameter T1H, default 70, SHALL set the high time of a 1 bit in clk cycles.
REQ-005 Parameter T_LATCH, default 5000, SHALL set the low hold time of a latch (reset) sequence in clk cycles.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 in_data  input  BITS  pixel word to transmit.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  encoder accepts in_data this cycle.
REQ-011 latch_req  input  1  single-cycle request for a latch sequence.
REQ-012 data_out  output  1  unipolar RZ line to the LED chain; registered.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 latch_done  output  1  one-cycle pulse at the end of a latch sequence.

Function
REQ-015 Elaboration SHALL fail unless 1 <= T0H < T1H < T_BIT, BITS >= 1 and T_LATCH >= 1; counter widths SHALL be sized with $clog2 of the largest count.
REQ-016 The FSM SHALL have states IDLE, BIT, LATCH.
REQ-017 A word SHALL be accepted on any cycle where in_valid and in_ready are both high.
REQ-018 In IDLE, in_ready SHALL be high only when no latch is pending and latch_req is low.
REQ-019 On acceptance from IDLE, the word SHALL be loaded into the shift register and the FSM SHALL enter BIT; data_out SHALL go high in the next cycle.
REQ-020 In BIT, data_out SHALL be high for exactly T0H or T1H cycles, selected by the current bit, then low for the rest of the T_BIT-cycle period.
REQ-021 Consecutive bits of one word SHALL follow with no gap; each bit period SHALL be exactly T_BIT cycles.
REQ-022 in_ready SHALL also be high during the final cycle of the last bit of a word, provided no latch is pending.
REQ-023 A word accepted in that final cycle SHALL begin its first bit on the next cycle, with no gap between words.
REQ-024 If no word is accepted in that final cycle and no latch is pending, the FSM SHALL return to IDLE with data_out low.
REQ-025 latch_req in IDLE SHALL enter LATCH on the next cycle; latch_req has priority over a simultaneous in_valid, so that word is not accepted.
REQ-026 latch_req during BIT SHALL set a pending flag; the current word SHALL complete and LATCH SHALL follow immediately.
REQ-027 While a latch is pending, no new word SHALL be accepted.
REQ-028 In LATCH, data_out SHALL be low for exactly T_LATCH cycles.
REQ-029 latch_done SHALL pulse in the final LATCH cycle, and the FSM SHALL then return to IDLE.
REQ-030 latch_req during LATCH SHALL be ignored; it does not extend or repeat the sequence.
REQ-031 in_data SHALL be sampled only at acceptance; later changes to in_data SHALL NOT affect the word in flight.

Reset
REQ-032 While rst is high, the FSM SHALL be IDLE and data_out, busy, latch_done and in_ready SHALL be 0.
REQ-033 The pending flag, shift register and counters SHALL be cleared during reset.
REQ-034 rst asserted mid-bit or mid-latch SHALL force data_out low on the next edge and abort the operation; no latch_done pulse SHALL be produced.
REQ-035 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
Bench parameters: BITS=8, T_BIT=10, T0H=3, T1H=6, T_LATCH=20.
REQ-036 Single word 8'hA5 accepted from IDLE -> 8 periods of 10 cycles; high widths 6,3,6,3,3,6,3,6; FSM then returns to IDLE, busy low.
REQ-037 Back-to-back 8'hFF then 8'h00, with in_valid held high -> second word accepted in the final cycle of the first; 160 contiguous cycles; high widths eight 6s then eight 3s.
REQ-038 latch_req at cycle 25 of a word in flight -> word completes at cycle 80; data_out low for 20 cycles; latch_done pulses at cycle 100; in_valid held high meanwhile is not accepted until IDLE.
REQ-039 latch_req and in_valid together in IDLE -> LATCH first (20 low cycles, latch_done); the word is accepted afterwards.
REQ-040 rst at cycle 2 of a 1-bit high phase -> data_out 0 on the next edge; busy 0; no latch_done; a fresh word after reset is transmitted correctly.
REQ-041 in_data changed every cycle after acceptance of 8'h81 -> transmitted widths stay 6,3,3,3,3,3,3,6.
